// File: rtl/load_store_unit.sv
// load_store_unit
// Load/store unit between execute and a doubleword-wide data memory.
// Accepts RV64 byte-addressed load/store requests (funct3 width/sign code)
// over valid/ready, checks alignment, and drives the memory port. Stores
// narrower than a doubleword use read-modify-write. Completion is a
// one-cycle resp_valid pulse carrying load data or the misaligned flag.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_write, req_funct3           store/load, width/sign code
//   req_addr, req_wdata             byte address, right-aligned store data
//   resp_valid                      one-cycle completion pulse
//   resp_rdata, resp_misaligned     load result / error flag (0 when idle)
//   mem_address, mem_write_data     doubleword index and write data
//   mem_read, mem_write             memory enables
//   mem_read_data                   combinational read data
module load_store_unit #(
    parameter int MEM_DEPTH_LOG2 = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [2:0]                req_funct3,
    input  logic [63:0]               req_addr,
    input  logic [63:0]               req_wdata,
    output logic                      resp_valid,
    output logic [63:0]               resp_rdata,
    output logic                      resp_misaligned,
    output logic [MEM_DEPTH_LOG2-1:0] mem_address,
    output logic [63:0]               mem_write_data,
    output logic                      mem_read,
    output logic                      mem_write,
    input  logic [63:0]               mem_read_data
);
    localparam int ADDR_W = MEM_DEPTH_LOG2 + 3;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state, state_next;
    logic              l_write;
    logic [2:0]        l_funct3;
    logic [ADDR_W-1:0] l_addr;
    logic [63:0]       l_wdata;
    logic [63:0]       dword_buf;

    logic              accept;
    logic              req_err;
    logic [5:0]        bit_shift;
    logic [63:0]       lane_data, load_data, size_mask, lane_mask, store_data;

    // Address bits above the memory window alias; they are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[63:ADDR_W];

    assign accept = req_valid && req_ready;

    // Misalignment by access size, plus the invalid funct3 codes
    // (111 for loads, any code with bit 2 set for stores).
    always_comb begin
        req_err = 1'b0;
        case (req_funct3[1:0])
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            2'b11:   req_err = |req_addr[2:0];
            default: req_err = 1'b0;
        endcase
        if (req_write ? req_funct3[2] : (req_funct3 == 3'b111))
            req_err = 1'b1;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                          state_next = RESP;
                    else if (req_write && req_funct3[1:0] == 2'b11) state_next = WRITE;
                    else                                  state_next = READ;
                end
            end
            READ:    state_next = l_write ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for narrow stores.
    assign bit_shift = {l_addr[2:0], 3'b000};

    always_comb begin
        lane_data = mem_read_data >> bit_shift;
        case (l_funct3[1:0])
            2'b00: load_data = l_funct3[2] ? {56'b0, lane_data[7:0]}
                                           : {{56{lane_data[7]}}, lane_data[7:0]};
            2'b01: load_data = l_funct3[2] ? {48'b0, lane_data[15:0]}
                                           : {{48{lane_data[15]}}, lane_data[15:0]};
            2'b10: load_data = l_funct3[2] ? {32'b0, lane_data[31:0]}
                                           : {{32{lane_data[31]}}, lane_data[31:0]};
            default: load_data = lane_data;
        endcase
    end

    always_comb begin
        case (l_funct3[1:0])
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        lane_mask  = size_mask << bit_shift;
        store_data = (dword_buf & ~lane_mask) | ((l_wdata << bit_shift) & lane_mask);
        if (l_funct3[1:0] == 2'b11)
            store_data = l_wdata;
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        req_ready      = (state == IDLE) && !reset;
        resp_valid     = (state == RESP);
        mem_read       = (state == READ);
        mem_write      = (state == WRITE);
        mem_address    = '0;
        mem_write_data = '0;
        if (state == READ || state == WRITE)
            mem_address = l_addr[ADDR_W-1:3];
        if (state == WRITE)
            mem_write_data = store_data;
    end

    // Request latch, read-back buffer and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_write         <= 1'b0;
            l_funct3        <= 3'b0;
            l_addr          <= '0;
            l_wdata         <= '0;
            dword_buf       <= '0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        l_write         <= req_write;
                        l_funct3        <= req_funct3;
                        l_addr          <= req_addr[ADDR_W-1:0];
                        l_wdata         <= req_wdata;
                        resp_misaligned <= req_err;
                    end
                end
                READ: begin
                    dword_buf <= mem_read_data;
                    if (!l_write) resp_rdata <= load_data;
                end
                RESP: begin
                    // Response fields read as zero outside the pulse.
                    resp_rdata      <= '0;
                    resp_misaligned <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and `data_memory`. Takes byte-addressed RV64 load/store requests (funct3-encoded width and sign), checks alignment, and drives the 64-entry doubleword `data_memory` port. Sub-doubleword stores use a read-modify-write sequence. Loads return lane-extracted, sign- or zero-extended data over a valid/ready request handshake and a one-cycle response pulse.

## Interface
- `MEM_DEPTH_LOG2`, default 6: doubleword index width; byte address space is 2^(MEM_DEPTH_LOG2+3) = 512 bytes.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE and only while `reset` is low.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  width/sign code.
- `req_addr`  in  64  byte address.
- `req_wdata`  in  64  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  64  load result; 0 for stores and errors.
- `resp_misaligned`  out  1  error flag, qualified by `resp_valid`.
- `mem_address`  out  6  doubleword index, `req_addr[8:3]`.
- `mem_write_data`  out  64  doubleword to write.
- `mem_read`  out  1  memory read enable.
- `mem_write`  out  1  memory write enable; memory writes on the `clk` rising edge.
- `mem_read_data`  in  64  combinational memory read data, valid in the same cycle as `mem_read`.

## Operation
- **States:** IDLE, READ, WRITE, RESP. The state, latched request, and captured doubleword are registered. Every `mem_*` output is decoded from the registered state only.
- **IDLE:** a request is accepted when `req_valid && req_ready` is sampled at the clock edge. The unit latches write, funct3, addr and wdata. `req_valid` is ignored in all other states.
- **Load funct3 codes:**
  - 000 lb, 001 lh, 010 lw, 011 ld
  - 100 lbu, 101 lhu, 110 lwu
  - 111 invalid
- **Store funct3 codes:** 000 sb, 001 sh, 010 sw, 011 sd; 100–111 invalid.
- **Error:** raised by an invalid funct3, or by misalignment:
  - h requires `addr[0]`=0
  - w requires `addr[1:0]`=0
  - d requires `addr[2:0]`=0
  
  On error the next state is RESP with `resp_misaligned`=1. No `mem_read` or `mem_write` is issued.
- **Load path:** IDLE → READ → RESP.
  - READ drives `mem_read`=1; the buffer captures `mem_read_data` at the edge.
  - Little-endian lanes: byte k = bits [8k+7:8k], with k = `addr[2:0]`.
  - Signed loads replicate the lane MSB; unsigned loads fill with zeros.
- **sd path:** IDLE → WRITE → RESP. WRITE drives `mem_write`=1 and `mem_write_data`=wdata.
- **sb/sh/sw path:** IDLE → READ → WRITE → RESP. WRITE drives the captured doubleword with only the addressed 1/2/4 byte lanes replaced by the low bytes of wdata.
- **RESP:** `resp_valid`=1 for exactly one cycle, then the unit returns to IDLE. There is no response backpressure.
- **Addressing:** `req_addr` bits [63:9] are ignored, so addresses wrap modulo 512 bytes (e.g. 0x3F8 aliases 0x1F8).
- **Idle outputs:** `mem_read`, `mem_write`, `mem_address` and `mem_write_data` are 0 in IDLE and RESP.
- **Reset values:** state IDLE; all outputs 0, including `req_ready` while `reset` is high.
- **Reset mid-operation:**
  - The unit goes to IDLE immediately and `mem_write`/`mem_read` drop asynchronously.
  - An aborted WRITE does not modify memory.
  - No `resp_valid` is issued for the aborted request.
  - `req_ready`=1 in the first cycle after `reset` deasserts.

## Timing
- **Acceptance:** the request is accepted at the end of cycle T.
- **Error:** RESP in T+1.
- **Load:** READ in T+1, RESP in T+2.
- **sd:** WRITE in T+1, RESP in T+2.
- **sb/sh/sw:** READ in T+1, WRITE in T+2, RESP in T+3.
- **Throughput:** `req_ready` is low from T+1 through RESP. The earliest next acceptance is the cycle after RESP, so a load occupies 3 cycles per request and a sub-doubleword store 4.
- **`resp_rdata`/`resp_misaligned`:** registered; stable only while `resp_valid`=1, and 0 otherwise.
- **`mem_write`:** high for exactly one cycle per store; `mem_read` is high for exactly one cycle per load or sub-doubleword store.

## Test plan
- **Doubleword round trip:** after reset, sd 0xDEADBEEF12345678 @0x000.
  - Required: `mem_write`=1 for one cycle with `mem_address`=0, then `resp_valid` at T+2.
  - Then ld @0x000 → `resp_rdata`=0xDEADBEEF12345678 at T+2, `resp_misaligned`=0.
- **Byte store and load:** sd 0x1122334455667788 @0x000, then sb 0x...AB @0x005.
  - Required: the write data in WRITE is 0x1122AB4455667788.
  - lb @0x005 → 0xFFFFFFFFFFFFFFAB; lbu @0x005 → 0x00000000000000AB.
- **Word store and load:** sw 0x80000000 @0x00C over 0 @dword 1.
  - lw @0x00C → 0xFFFFFFFF80000000; lwu → 0x0000000080000000.
  - ld @0x008 → 0x8000000000000000 (lower half untouched).
- **Errors:** lh @0x003, sw @0x006, and a load with funct3=111.
  - Required for each: `resp_valid` at T+1 with `resp_misaligned`=1, `resp_rdata`=0, and `mem_read`=`mem_write`=0 throughout.
- **Reset mid-store:** sh 0xBEEF @0x010, with `reset` asserted during WRITE.
  - Required: `mem_write` falls immediately and no `resp_valid`.
  - ld @0x010 after deassert returns the old value.
  - `req_ready`=1 in the first cycle after deassert.
- **Wrap and busy:** sd 0x0123456789ABCDEF @0x1F8, then ld @0x3F8 → 0x0123456789ABCDEF.
  - Required: `req_valid` held high during READ is not accepted, and exactly one response is produced per accepted request.
